// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits, overlapping or
// non-overlapping) with a registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic               inp,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1010);
  localparam logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(4);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_match;
  logic               r_cfg_err;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_pat_eq;
  logic               w_hit;
  logic               w_len_ok;

  // A cfg_load cycle never consumes the stream bit, even if in_valid is high.
  assign w_accept   = in_valid & ~cfg_load;
  assign w_cand     = {r_hist[MAX_LEN-2:0], inp};
  assign w_fill_inc = {1'b0, r_fill} + 1'b1;
  assign w_len_ok   = (len_in != '0) && (len_in <= MAX_LEN_L);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (r_len > LEN_W'(i));
    end
  end

  always_comb begin
    w_pat_eq    = (((w_cand ^ r_pattern) & w_mask) == '0);
    w_hit       = w_accept && (w_fill_inc >= {1'b0, r_len}) && w_pat_eq;
    w_fill_next = (r_fill == MAX_LEN_L) ? r_fill : w_fill_inc[LEN_W-1:0];
  end

  // Stream history, fill level and active configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= DEF_PATTERN;
      r_len     <= DEF_LEN;
      r_overlap <= 1'b1;
    end else if (cfg_load) begin
      r_hist <= '0;
      r_fill <= '0;
      if (w_len_ok) begin
        r_pattern <= pattern_in;
        r_len     <= len_in;
        r_overlap <= overlap_in;
      end
    end else if (w_accept) begin
      r_hist <= w_cand;
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_hit;
      r_cfg_err <= cfg_load & ~w_len_ok;
    end
  end

  // A clear coinciding with a hit leaves the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= w_hit ? CNT_W'(1) : '0;
    end else if (w_hit && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign match       = r_match;
  assign cfg_err     = r_cfg_err;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (MAX_LEN=8, CNT_W=2) with immediate
// assertions at every comparison point.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap_in;
  logic               cnt_clr;
  logic               in_valid;
  logic               inp;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int total;
  int bad;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .pattern_in (pattern_in),
    .len_in     (len_in),
    .overlap_in (overlap_in),
    .cnt_clr    (cnt_clr),
    .in_valid   (in_valid),
    .inp        (inp),
    .match      (match),
    .match_count(match_count),
    .cfg_err    (cfg_err)
  );

  // Clock and global timeout
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted bit, then check the registered match pulse.
  task automatic send_bit(input logic b, input logic exp_m, input string tag);
    in_valid = 1'b1;
    inp      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inp      = 1'b0;
    chk(tag, {7'd0, match}, {7'd0, exp_m});
  endtask

  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk(tag, {7'd0, match}, 8'd0);
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ov, input logic exp_err, input string tag);
    cfg_load   = 1'b1;
    pattern_in = pat;
    len_in     = len;
    overlap_in = ov;
    in_valid   = 1'b1;
    inp        = pat[0];
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_err"}, {7'd0, cfg_err}, {7'd0, exp_err});
    chk({tag, "_match"}, {7'd0, match}, 8'd0);
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cnt_clr", {6'd0, match_count}, 8'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    cfg_load   = 1'b0;
    pattern_in = '0;
    len_in     = '0;
    overlap_in = 1'b0;
    cnt_clr    = 1'b0;
    in_valid   = 1'b0;
    inp        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_match", {7'd0, match}, 8'd0);
    chk("rst_err", {7'd0, cfg_err}, 8'd0);
    chk("rst_count", {6'd0, match_count}, 8'd0);

    // Defaults: 1010, len 4, overlapping
    send_bit(1'b1, 1'b0, "def_b1");
    send_bit(1'b0, 1'b0, "def_b2");
    send_bit(1'b1, 1'b0, "def_b3");
    send_bit(1'b0, 1'b1, "def_b4");
    send_bit(1'b1, 1'b0, "def_b5");
    send_bit(1'b0, 1'b1, "def_b6");
    chk("def_count", {6'd0, match_count}, 8'd2);
    clear_count();

    // Non-overlapping 1010
    load_cfg(8'h0A, 4'd4, 1'b0, 1'b0, "cfg_nov");
    send_bit(1'b1, 1'b0, "nov_b1");
    send_bit(1'b0, 1'b0, "nov_b2");
    send_bit(1'b1, 1'b0, "nov_b3");
    send_bit(1'b0, 1'b1, "nov_b4");
    send_bit(1'b1, 1'b0, "nov_b5");
    send_bit(1'b0, 1'b0, "nov_b6");
    send_bit(1'b1, 1'b0, "nov_b7");
    send_bit(1'b0, 1'b1, "nov_b8");
    chk("nov_count", {6'd0, match_count}, 8'd2);
    clear_count();

    // Illegal lengths keep the config but clear history
    send_bit(1'b1, 1'b0, "pre_b1");
    send_bit(1'b0, 1'b0, "pre_b2");
    load_cfg(8'hFF, 4'd0, 1'b1, 1'b1, "bad_len0");
    idle_cycle("bad_idle");
    chk("bad_err_gone", {7'd0, cfg_err}, 8'd0);
    send_bit(1'b1, 1'b0, "bad_b1");
    send_bit(1'b0, 1'b0, "bad_b2");
    send_bit(1'b1, 1'b0, "bad_b3");
    send_bit(1'b0, 1'b1, "bad_b4");
    load_cfg(8'hFF, 4'd9, 1'b1, 1'b1, "bad_len9");
    send_bit(1'b1, 1'b0, "bad9_b1");
    send_bit(1'b0, 1'b0, "bad9_b2");
    send_bit(1'b1, 1'b0, "bad9_b3");
    send_bit(1'b0, 1'b1, "bad9_b4");
    clear_count();

    // len 3, pattern 110, with idle gaps
    load_cfg(8'h06, 4'd3, 1'b1, 1'b0, "cfg_l3");
    send_bit(1'b1, 1'b0, "gap_b1");
    idle_cycle("gap_i1a");
    idle_cycle("gap_i1b");
    send_bit(1'b1, 1'b0, "gap_b2");
    idle_cycle("gap_i2a");
    idle_cycle("gap_i2b");
    send_bit(1'b1, 1'b0, "gap_b3");
    idle_cycle("gap_i3a");
    idle_cycle("gap_i3b");
    send_bit(1'b0, 1'b1, "gap_b4");
    idle_cycle("gap_after");
    chk("gap_count", {6'd0, match_count}, 8'd1);
    clear_count();

    // len 1 and counter saturation at 3
    load_cfg(8'h01, 4'd1, 1'b0, 1'b0, "cfg_l1");
    send_bit(1'b1, 1'b1, "sat_b1");
    chk("sat_c1", {6'd0, match_count}, 8'd1);
    send_bit(1'b1, 1'b1, "sat_b2");
    send_bit(1'b0, 1'b0, "sat_zero");
    send_bit(1'b1, 1'b1, "sat_b3");
    chk("sat_c3", {6'd0, match_count}, 8'd3);
    send_bit(1'b1, 1'b1, "sat_b4");
    send_bit(1'b1, 1'b1, "sat_b5");
    chk("sat_hold", {6'd0, match_count}, 8'd3);
    cnt_clr = 1'b1;
    send_bit(1'b1, 1'b1, "clr_hit");
    cnt_clr = 1'b0;
    chk("clr_hit_cnt", {6'd0, match_count}, 8'd1);
    load_cfg(8'h01, 4'd1, 1'b0, 1'b0, "cfg_keep");
    chk("cfg_keeps_cnt", {6'd0, match_count}, 8'd1);

    // Reset mid-pattern restores default config and drops history
    do_reset();
    chk("rst2_count", {6'd0, match_count}, 8'd0);
    send_bit(1'b1, 1'b0, "rst_b1");
    send_bit(1'b0, 1'b0, "rst_b2");
    send_bit(1'b1, 1'b0, "rst_b3");
    do_reset();
    send_bit(1'b0, 1'b0, "post_b1");
    send_bit(1'b1, 1'b0, "post_b2");
    send_bit(1'b0, 1'b0, "post_b3");
    send_bit(1'b1, 1'b0, "post_n1");
    send_bit(1'b0, 1'b1, "post_n2");
    send_bit(1'b1, 1'b0, "post_n3");
    send_bit(1'b0, 1'b1, "post_n4");
    chk("post_count", {6'd0, match_count}, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector and the successor to the fixed 4-bit "1010" Mealy detector. It watches a 1-bit qualified input stream for a runtime-programmable pattern of 1..MAX_LEN bits and supports overlapping or non-overlapping detection. It emits a registered match pulse and keeps a saturating match counter. It sits on serial data paths (line decoders, frame-sync hunting) between the bit source and the control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits; must be >= 4.
CNT_W, 8, width of the saturating match counter.
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_load  input  1  load pattern_in/len_in/overlap_in this cycle
pattern_in  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
len_in  input  LEN_W  pattern length, legal range 1..MAX_LEN
overlap_in  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  clear match_count
in_valid  input  1  inp is a valid stream bit this cycle
inp  input  1  serial data bit
match  output  1  one-cycle pulse, registered
match_count  output  CNT_W  saturating count of matches
cfg_err  output  1  one-cycle pulse: cfg_load carried an illegal len_in

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk; all state updates on the posedge of clk.
- Reset values:
  - match=0, cfg_err=0, match_count=0.
  - History register and fill counter are 0.
  - Active configuration is pattern=...1010 (low 4 bits, upper bits 0), len=4, overlap=1.
- Internal state:
  - hist: MAX_LEN-bit shift register of accepted bits.
  - fill: count of accepted bits since the last restart, saturating at MAX_LEN.
- Bit acceptance: a bit is accepted only when in_valid=1 and cfg_load=0. When in_valid=0, all state holds and match=0 next cycle.
- On each accepted bit:
  - cand = {hist[MAX_LEN-2:0], inp}.
  - hit = (fill+1 >= len) AND (cand[len-1:0] == pattern[len-1:0]).
  - hist <= cand.
  - fill <= min(fill+1, MAX_LEN).
- On hit:
  - match=1 on the following cycle (latency 1 clk from the accepting edge).
  - overlap=1: hist and fill continue unchanged, so the pattern suffix can start the next match.
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
- Configuration load:
  - cfg_load=1 with 1 <= len_in <= MAX_LEN: the active configuration is replaced and hist and fill are cleared. inp is ignored that cycle and match=0 next cycle.
  - cfg_load=1 with len_in=0 or len_in>MAX_LEN: the configuration is unchanged, hist and fill are still cleared, and cfg_err=1 for one cycle.
- match_count:
  - Increments on each hit and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0. If cnt_clr and a hit occur in the same cycle, match_count=1.
  - A valid cfg_load does not clear match_count.
- Reset mid-pattern: partial history is discarded and the configuration returns to the defaults. No match is produced for bits accepted before reset.
- len=1: every accepted bit equal to pattern[0] produces a match, in either overlap mode.

Test Plan:
- Defaults after reset, bits 1,0,1,0,1,0 with in_valid=1 every cycle -> match pulses after bit 4 and bit 6; match_count=2.
- cfg_load with pattern=...1010, len=4, overlap=0, then bits 1,0,1,0,1,0,1,0 -> match after bit 4 and bit 8 only; match_count=2.
- Load len=3, pattern=...110, overlap=1, then bits 1,1,1,0 with in_valid gaps of 2 cycles between bits -> a single match, 1 clk after bit 4 is accepted; match stays 0 during the gaps.
- cfg_load with len_in=0 -> cfg_err pulses for 1 cycle; a following 1,0,1,0 still matches under the previous 4-bit pattern.
- CNT_W=2, with len=1, pattern[0]=1, drive 5 ones -> match_count stops at 3. Then cnt_clr together with a matching bit -> match_count=1.
- Bits 1,0,1, then reset for one cycle, then 0,1,0 -> no match. The next 1,0,1,0 -> match after its 4th bit.
